execute_stage_md: RTL and testbench

EXECUTE_STAGE_MD -- requirements
Module: execute_stage_md

---
 rtl/execute_stage_md.sv | 222 ++++++++++++++++++++++
 tb/tb_execute_stage_md.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_md.sv
// execute_stage_md -- RISC-V style execute stage with an iterative unsigned
// mul/div unit and the E->M pipeline register.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   flush_e, valid_e    squash / valid for the E-stage instruction
//   *_e controls        regwrite, memwrite, branch, jump, alusrc, md, resultsrc,
//                       alu_ctrl, md_op, funct3
//   rd1_e, rd2_e, imm_e, pc_e, pcplus4_e, result_w   operands / W forward value
//   rd_e                destination register
//   fwd_a_e, fwd_b_e    forwarding selects (00 regfile, 01 W, 10 M, 11 regfile)
//   pc_target_e, pc_src_e   branch/jump redirect (combinational)
//   busy_e              stall request while a mul/div op is in flight
//   *_m                 registered M-stage controls and data
//
// Stall handshake: busy_e is a combinational stall request. While it is high
// the upstream stages must hold the E-stage instruction (including valid_e and
// md_e) unchanged; this stage loads a bubble into M each such cycle. busy_e
// falls in the DONE cycle, during which the held instruction retires into M
// with the mul/div result, and the pipeline may advance on that edge.
module execute_stage_md #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_e,
    input  logic            valid_e,
    input  logic            regwrite_e,
    input  logic            memwrite_e,
    input  logic            branch_e,
    input  logic            jump_e,
    input  logic            alusrc_e,
    input  logic            md_e,
    input  logic [1:0]      resultsrc_e,
    input  logic [3:0]      alu_ctrl_e,
    input  logic [1:0]      md_op_e,
    input  logic [2:0]      funct3_e,
    input  logic [XLEN-1:0] rd1_e,
    input  logic [XLEN-1:0] rd2_e,
    input  logic [XLEN-1:0] imm_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] pcplus4_e,
    input  logic [XLEN-1:0] result_w,
    input  logic [RA_W-1:0] rd_e,
    input  logic [1:0]      fwd_a_e,
    input  logic [1:0]      fwd_b_e,
    output logic [XLEN-1:0] pc_target_e,
    output logic            pc_src_e,
    output logic            busy_e,
    output logic            valid_m,
    output logic            regwrite_m,
    output logic            memwrite_m,
    output logic [1:0]      resultsrc_m,
    output logic [RA_W-1:0] rd_m,
    output logic [XLEN-1:0] pcplus4_m,
    output logic [XLEN-1:0] writedata_m,
    output logic [XLEN-1:0] alu_result_m
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;

    md_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  hi_q;   // product high half / partial remainder
    logic [XLEN-1:0]  lo_q;   // multiplier bits -> product low half / quotient
    logic [XLEN-1:0]  b_q;    // latched multiplicand / divisor
    logic [1:0]       op_q;

    // ---------------- forwarding and ALU ----------------
    logic [XLEN-1:0] fa, fb, srcb, alu_y;
    logic [SH_W-1:0] shamt;
    logic            cond;
    logic            md_issue;

    always_comb begin
        case (fwd_a_e)
            2'b01:   fa = result_w;
            2'b10:   fa = alu_result_m;
            default: fa = rd1_e;
        endcase
        case (fwd_b_e)
            2'b01:   fb = result_w;
            2'b10:   fb = alu_result_m;
            default: fb = rd2_e;
        endcase
    end

    assign srcb  = alusrc_e ? imm_e : fb;
    assign shamt = srcb[SH_W-1:0];

    always_comb begin
        case (alu_ctrl_e)
            4'd0:    alu_y = fa + srcb;
            4'd1:    alu_y = fa - srcb;
            4'd2:    alu_y = fa & srcb;
            4'd3:    alu_y = fa | srcb;
            4'd4:    alu_y = fa ^ srcb;
            4'd5:    alu_y = {{(XLEN-1){1'b0}}, ($signed(fa) < $signed(srcb))};
            4'd6:    alu_y = {{(XLEN-1){1'b0}}, (fa < srcb)};
            4'd7:    alu_y = fa << shamt;
            4'd8:    alu_y = fa >> shamt;
            4'd9:    alu_y = $unsigned($signed(fa) >>> shamt);
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        case (funct3_e)
            3'b000:  cond = (fa == fb);
            3'b001:  cond = (fa != fb);
            3'b100:  cond = ($signed(fa) < $signed(fb));
            3'b101:  cond = ($signed(fa) >= $signed(fb));
            3'b110:  cond = (fa < fb);
            3'b111:  cond = (fa >= fb);
            default: cond = 1'b0;
        endcase
    end

    assign pc_target_e = pc_e + imm_e;
    assign pc_src_e    = valid_e & ~flush_e & (jump_e | (branch_e & cond));

    assign md_issue = valid_e & md_e & ~flush_e;
    assign busy_e   = md_issue & (state_q != MD_DONE);

    // ---------------- one mul/div iteration ----------------
    // Multiply: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the {hi, lo} pair right by one.
    // Divide: restoring division; shift the next dividend bit into the
    // remainder, keep the trial subtraction if it did not borrow.
    // A zero divisor never borrows, so quotient = all ones and the remainder
    // accumulates the dividend without any special casing.
    logic [XLEN:0]   mul_sum, div_shift, div_trial;
    logic            div_ge;
    logic [XLEN-1:0] hi_d, lo_d, md_result;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_trial = div_shift - {1'b0, b_q};
    assign div_ge    = ~div_trial[XLEN];

    always_comb begin
        if (!op_q[1]) begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
            hi_d = div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ge};
        end
    end

    // MUL/DIVU read the low register, MULHU/REMU the high one.
    assign md_result = op_q[0] ? hi_q : lo_q;

    // ---------------- mul/div FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else if (flush_e) begin
            state_q <= MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md_issue) begin
                        state_q <= MD_RUN;
                        cnt_q   <= CNT_W'(XLEN);
                        hi_q    <= '0;
                        lo_q    <= fa;
                        b_q     <= fb;
                        op_q    <= md_op_e;
                    end
                end
                MD_RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= MD_DONE;
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    // ---------------- E->M pipeline register ----------------
    // Data fields load every cycle; on bubbles their value is irrelevant
    // because valid_m/regwrite_m/memwrite_m are cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_m      <= 1'b0;
            regwrite_m   <= 1'b0;
            memwrite_m   <= 1'b0;
            resultsrc_m  <= '0;
            rd_m         <= '0;
            pcplus4_m    <= '0;
            writedata_m  <= '0;
            alu_result_m <= '0;
        end else begin
            resultsrc_m  <= resultsrc_e;
            rd_m         <= rd_e;
            pcplus4_m    <= pcplus4_e;
            writedata_m  <= fb;
            alu_result_m <= (state_q == MD_DONE) ? md_result : alu_y;
            if (flush_e || busy_e) begin
                valid_m    <= 1'b0;
                regwrite_m <= 1'b0;
                memwrite_m <= 1'b0;
            end else begin
                valid_m    <= valid_e;
                regwrite_m <= regwrite_e & valid_e;
                memwrite_m <= memwrite_e & valid_e;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage_md.sv
module tb_execute_stage_md;
    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic            clk, rst;
    logic            flush_e, valid_e, regwrite_e, memwrite_e, branch_e, jump_e, alusrc_e, md_e;
    logic [1:0]      resultsrc_e, md_op_e, fwd_a_e, fwd_b_e;
    logic [3:0]      alu_ctrl_e;
    logic [2:0]      funct3_e;
    logic [XLEN-1:0] rd1_e, rd2_e, imm_e, pc_e, pcplus4_e, result_w;
    logic [RA_W-1:0] rd_e;
    logic [XLEN-1:0] pc_target_e;
    logic            pc_src_e, busy_e, valid_m, regwrite_m, memwrite_m;
    logic [1:0]      resultsrc_m;
    logic [RA_W-1:0] rd_m;
    logic [XLEN-1:0] pcplus4_m, writedata_m, alu_result_m;

    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN-1:0] exp_q[$];

    execute_stage_md #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst), .flush_e(flush_e), .valid_e(valid_e),
        .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .branch_e(branch_e),
        .jump_e(jump_e), .alusrc_e(alusrc_e), .md_e(md_e),
        .resultsrc_e(resultsrc_e), .alu_ctrl_e(alu_ctrl_e), .md_op_e(md_op_e),
        .funct3_e(funct3_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
        .pc_e(pc_e), .pcplus4_e(pcplus4_e), .result_w(result_w), .rd_e(rd_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .pc_target_e(pc_target_e),
        .pc_src_e(pc_src_e), .busy_e(busy_e), .valid_m(valid_m),
        .regwrite_m(regwrite_m), .memwrite_m(memwrite_m),
        .resultsrc_m(resultsrc_m), .rd_m(rd_m), .pcplus4_m(pcplus4_m),
        .writedata_m(writedata_m), .alu_result_m(alu_result_m)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        logic [63:0] ext;
        sh  = int'(b % 32);
        ext = {{32{a[31]}}, a};
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << sh;
            4'd8: return a >> sh;
            4'd9: begin
                ext = ext >> sh;
                return ext[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00: return p[31:0];
            2'b01: return p[63:32];
            2'b10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_e = 0; valid_e = 0; regwrite_e = 0; memwrite_e = 0; branch_e = 0;
        jump_e = 0; alusrc_e = 0; md_e = 0; resultsrc_e = 0; md_op_e = 0;
        fwd_a_e = 0; fwd_b_e = 0; alu_ctrl_e = 0; funct3_e = 3'b010;
        rd1_e = 0; rd2_e = 0; imm_e = 0; pc_e = 0; pcplus4_e = 0; result_w = 0; rd_e = 0;
    endtask

    // Issue one mul/div op, scramble the E-stage operands while it runs, and
    // check busy length, bubbles and the final M-stage result.
    task automatic run_md(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int busy_cnt;
        int valid_seen;
        logic [RA_W-1:0] dest;
        logic [31:0] exp;
        exp  = ref_md(op, a, b);
        dest = RA_W'($urandom_range(1, 31));
        valid_e = 1; md_e = 1; md_op_e = op; regwrite_e = 1; memwrite_e = 0;
        rd1_e = a; rd2_e = b; fwd_a_e = 0; fwd_b_e = 0; alusrc_e = 0;
        alu_ctrl_e = 4'($urandom_range(0, 15)); rd_e = dest; resultsrc_e = 0;
        branch_e = 0; jump_e = 0; flush_e = 0;
        busy_cnt = 0;
        valid_seen = 0;
        for (int k = 0; k < XLEN + 1; k++) begin
            #1;
            if (busy_e) busy_cnt++;
            tick();
            if (valid_m) valid_seen++;
            rd1_e = $urandom; rd2_e = $urandom; result_w = $urandom;
            fwd_a_e = 2'($urandom_range(0, 3)); fwd_b_e = 2'($urandom_range(0, 3));
        end
        #1;
        check({tag, "_busy_done"}, {63'd0, busy_e}, 64'd0);
        check({tag, "_busy_len"}, 64'(busy_cnt), 64'(XLEN + 1));
        check({tag, "_bubbles"}, 64'(valid_seen), 64'd0);
        exp_q.push_back(exp);
        tick();
        check({tag, "_result"}, {32'd0, alu_result_m}, {32'd0, exp_q.pop_front()});
        check({tag, "_valid_m"}, {63'd0, valid_m}, 64'd1);
        check({tag, "_regwrite_m"}, {63'd0, regwrite_m}, 64'd1);
        check({tag, "_rd_m"}, 64'(rd_m), 64'(dest));
        idle_inputs();
        #1;
        check({tag, "_busy_after"}, {63'd0, busy_e}, 64'd0);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] fa, fb, srcb, m_val, e_alu;
        logic        m_known, e_src;
        int          quiet;

        idle_inputs();
        rst = 0;
        #3;
        check("rst_valid_m", {63'd0, valid_m}, 64'd0);
        check("rst_alu_result_m", {32'd0, alu_result_m}, 64'd0);
        check("rst_busy", {63'd0, busy_e}, 64'd0);
        tick();
        tick();
        rst = 1;
        tick();

        // forward from W, immediate operand
        valid_e = 1; regwrite_e = 1; rd1_e = 5; fwd_a_e = 2'b01; result_w = 7;
        imm_e = 3; alusrc_e = 1; alu_ctrl_e = 0; rd_e = 3;
        tick();
        check("fwd_add_result", {32'd0, alu_result_m}, 64'd10);
        check("fwd_add_valid", {63'd0, valid_m}, 64'd1);
        check("fwd_add_rd", 64'(rd_m), 64'd3);

        // branch conditions: signed vs unsigned compare of -1 and 1
        idle_inputs();
        valid_e = 1; branch_e = 1; funct3_e = 3'b100; rd1_e = 32'hFFFF_FFFF; rd2_e = 1;
        pc_e = 32'h100; imm_e = 32'h20;
        #1;
        check("blt_taken", {63'd0, pc_src_e}, 64'd1);
        check("pc_target", {32'd0, pc_target_e}, 64'h120);
        funct3_e = 3'b110;
        #1;
        check("bltu_not_taken", {63'd0, pc_src_e}, 64'd0);
        funct3_e = 3'b100; flush_e = 1;
        #1;
        check("branch_flushed", {63'd0, pc_src_e}, 64'd0);
        tick();
        check("flush_bubble", {63'd0, valid_m}, 64'd0);
        idle_inputs();
        tick();

        // randomized ALU / branch traffic against the model
        m_known = 0;
        m_val   = 0;
        for (int i = 0; i < 60; i++) begin
            flush_e     = ($urandom_range(0, 7) == 0);
            valid_e     = ($urandom_range(0, 5) != 0);
            regwrite_e  = 1'($urandom_range(0, 1));
            memwrite_e  = 1'($urandom_range(0, 1));
            branch_e    = 1'($urandom_range(0, 1));
            jump_e      = ($urandom_range(0, 5) == 0);
            alusrc_e    = 1'($urandom_range(0, 1));
            md_e        = 0;
            resultsrc_e = 2'($urandom_range(0, 3));
            alu_ctrl_e  = 4'($urandom_range(0, 15));
            funct3_e    = 3'($urandom_range(0, 7));
            rd1_e       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rd2_e       = ($urandom_range(0, 3) == 0) ? rd1_e : $urandom;
            imm_e       = $urandom; pc_e = $urandom; pcplus4_e = $urandom;
            result_w    = $urandom; rd_e = RA_W'($urandom_range(0, 31));
            fwd_a_e     = 2'($urandom_range(0, 3));
            fwd_b_e     = 2'($urandom_range(0, 3));
            if (!m_known && fwd_a_e == 2'b10) fwd_a_e = 2'b00;
            if (!m_known && fwd_b_e == 2'b10) fwd_b_e = 2'b00;
            fa = (fwd_a_e == 2'b01) ? result_w : (fwd_a_e == 2'b10) ? m_val : rd1_e;
            fb = (fwd_b_e == 2'b01) ? result_w : (fwd_b_e == 2'b10) ? m_val : rd2_e;
            srcb  = alusrc_e ? imm_e : fb;
            e_alu = ref_alu(alu_ctrl_e, fa, srcb);
            e_src = valid_e && !flush_e && (jump_e || (branch_e && ref_cond(funct3_e, fa, fb)));
            #1;
            check("rnd_pc_target", {32'd0, pc_target_e}, {32'd0, pc_e + imm_e});
            check("rnd_pc_src", {63'd0, pc_src_e}, {63'd0, e_src});
            exp_q.push_back(e_alu);
            tick();
            e_alu = exp_q.pop_front();
            if (flush_e) begin
                check("rnd_flush_valid", {63'd0, valid_m}, 64'd0);
                check("rnd_flush_regwrite", {63'd0, regwrite_m}, 64'd0);
                check("rnd_flush_memwrite", {63'd0, memwrite_m}, 64'd0);
                m_known = 0;
            end else begin
                check("rnd_alu_result", {32'd0, alu_result_m}, {32'd0, e_alu});
                check("rnd_valid_m", {63'd0, valid_m}, {63'd0, valid_e});
                check("rnd_regwrite_m", {63'd0, regwrite_m}, {63'd0, regwrite_e & valid_e});
                check("rnd_memwrite_m", {63'd0, memwrite_m}, {63'd0, memwrite_e & valid_e});
                check("rnd_resultsrc_m", 64'(resultsrc_m), 64'(resultsrc_e));
                check("rnd_rd_m", 64'(rd_m), 64'(rd_e));
                check("rnd_pcplus4_m", {32'd0, pcplus4_m}, {32'd0, pcplus4_e});
                check("rnd_writedata_m", {32'd0, writedata_m}, {32'd0, fb});
                m_known = 1;
                m_val   = e_alu;
            end
        end
        idle_inputs();
        tick();

        // directed mul/div cases
        run_md("mulhu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md("divu_zero", 2'b10, 32'd100, 32'd0);
        run_md("remu_zero", 2'b11, 32'd100, 32'd0);
        run_md("remu_100_7", 2'b11, 32'd100, 32'd7);
        run_md("divu_100_7", 2'b10, 32'd100, 32'd7);
        run_md("mul_small", 2'b00, 32'd123, 32'd456);

        // flush during RUN cycle 10
        valid_e = 1; md_e = 1; md_op_e = 2'b00; rd1_e = 32'h1234; rd2_e = 32'h77; regwrite_e = 1;
        for (int k = 0; k < 10; k++) tick();
        flush_e = 1;
        #1;
        check("flush_run_busy", {63'd0, busy_e}, 64'd0);
        tick();
        check("flush_run_valid_m", {63'd0, valid_m}, 64'd0);
        idle_inputs();
        quiet = 0;
        for (int k = 0; k < XLEN + 8; k++) begin
            tick();
            if (valid_m || busy_e) quiet++;
        end
        check("flush_no_late_result", 64'(quiet), 64'd0);
        run_md("mul_after_flush", 2'b00, 32'd3, 32'd5);

        // reset mid-RUN
        valid_e = 1; md_e = 1; md_op_e = 2'b01; rd1_e = 32'hDEAD_BEEF; rd2_e = 32'h55; regwrite_e = 1;
        rd_e = 5'd9; pcplus4_e = 32'h44;
        for (int k = 0; k < 6; k++) tick();
        #2;
        rst = 0;
        #1;
        check("rst_run_valid_m", {63'd0, valid_m}, 64'd0);
        check("rst_run_alu_result", {32'd0, alu_result_m}, 64'd0);
        check("rst_run_rd_m", 64'(rd_m), 64'd0);
        check("rst_run_pcplus4_m", {32'd0, pcplus4_m}, 64'd0);
        check("rst_run_writedata_m", {32'd0, writedata_m}, 64'd0);
        check("rst_run_busy_inputs", {63'd0, busy_e}, 64'd1);
        idle_inputs();
        tick();
        tick();
        rst = 1;
        quiet = 0;
        for (int k = 0; k < XLEN + 8; k++) begin
            tick();
            if (valid_m || busy_e) quiet++;
        end
        check("rst_no_late_result", 64'(quiet), 64'd0);
        run_md("mul_6x7", 2'b00, 32'd6, 32'd7);

        // randomized mul/div against the model
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 :
                ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            run_md("rnd_md", 2'($urandom_range(0, 3)), a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
